// File: rtl/hazard3_uop_issue_ctrl.sv
// hazard3_uop_issue_ctrl
//
// Issue controller sitting between the fetch/instruction buffer and the
// instruction decompressor. It holds one instruction, presents it to the
// decompressor for as many cycles as its uop sequence needs, sequences the
// decompressor's uop step counter through stall/clear, decides when an
// interrupt may cut into a Zcmp uop sequence and drops state on flush.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   fd_valid/fd_instr     instruction offered by fetch
//   fd_ready              offered instruction accepted this cycle
//   dc_instr_in           held instruction, to the decompressor
//   dc_is_uop             decompressor output is a uop
//   dc_is_final_uop       current uop is the last of its sequence
//   dc_uop_atomic         current uop must not be interrupted
//   dc_uop_stall          hold the decompressor uop counter
//   dc_uop_clear          reset the decompressor uop counter to 0
//   x_stall               downstream cannot accept an issue
//   x_flush               pipeline redirect, discard held instruction
//   irq_req               interrupt pending (level)
//   irq_take              interrupt taken this cycle (pulse)
//   d_valid               uop/instruction issued downstream this cycle
//   d_retire              held instruction completes this cycle
//   uop_cnt               uops issued for the held instruction (registered)
//   err_overlong          sticky: a sequence reached MAX_UOPS uops
module hazard3_uop_issue_ctrl #(
  parameter int unsigned MAX_UOPS = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fd_valid,
  input  logic [31:0] fd_instr,
  output logic        fd_ready,
  output logic [31:0] dc_instr_in,
  input  logic        dc_is_uop,
  input  logic        dc_is_final_uop,
  input  logic        dc_uop_atomic,
  output logic        dc_uop_stall,
  output logic        dc_uop_clear,
  input  logic        x_stall,
  input  logic        x_flush,
  input  logic        irq_req,
  output logic        irq_take,
  output logic        d_valid,
  output logic        d_retire,
  output logic [4:0]  uop_cnt,
  output logic        err_overlong
);

  localparam logic [4:0] MAX_CNT = 5'(MAX_UOPS);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_HELD  = 2'd1,
    ST_SEQ   = 2'd2
  } state_t;

  state_t      state_r,    state_nxt_s;
  logic [31:0] ir_r,       ir_nxt_s;
  logic        ir_valid_r, ir_valid_nxt_s;
  logic [4:0]  uop_cnt_r,  uop_cnt_nxt_s;
  logic        err_r,      err_nxt_s;

  logic vld_s;
  logic seq_atomic_s;
  logic can_irq_s;
  logic issue_s;
  logic retire_s;
  logic take_s;
  logic clear_s;
  logic accept_s;

  // The held instruction is qualified with rst_n so that nothing issues,
  // retires or takes an interrupt while reset is asserted at the edge.
  assign vld_s        = ir_valid_r & rst_n;
  // Only an atomic uop inside a running sequence blocks interrupts; the
  // first uop (still HELD) can always be interrupted.
  assign seq_atomic_s = (state_r == ST_SEQ) & dc_uop_atomic;
  assign can_irq_s    = vld_s & ~x_stall & irq_req & ~seq_atomic_s;
  assign issue_s      = vld_s & ~x_stall & ~x_flush & ~can_irq_s;
  assign retire_s     = issue_s & (~dc_is_uop | dc_is_final_uop);
  assign take_s       = can_irq_s & ~x_flush;
  assign clear_s      = x_flush | take_s | ~rst_n;
  assign accept_s     = rst_n & ~x_flush & (~ir_valid_r | retire_s);

  assign dc_instr_in  = ir_r;
  assign d_valid      = issue_s;
  assign d_retire     = retire_s;
  assign irq_take     = take_s;
  assign dc_uop_clear = clear_s;
  assign dc_uop_stall = ~issue_s & ~clear_s;
  assign fd_ready     = accept_s;
  assign uop_cnt      = uop_cnt_r;
  assign err_overlong = err_r;

  // Next-state: flush beats interrupt beats issue; loads happen on accept.
  always_comb begin
    state_nxt_s    = state_r;
    ir_nxt_s       = ir_r;
    ir_valid_nxt_s = ir_valid_r;
    uop_cnt_nxt_s  = uop_cnt_r;
    err_nxt_s      = err_r;
    if (x_flush) begin
      state_nxt_s    = ST_EMPTY;
      ir_valid_nxt_s = 1'b0;
      uop_cnt_nxt_s  = 5'd0;
    end else if (take_s) begin
      // ir is kept so the instruction restarts from uop 0 after the handler
      state_nxt_s   = ST_HELD;
      uop_cnt_nxt_s = 5'd0;
    end else if (retire_s) begin
      if (fd_valid) begin
        state_nxt_s    = ST_HELD;
        ir_nxt_s       = fd_instr;
        ir_valid_nxt_s = 1'b1;
        uop_cnt_nxt_s  = 5'd0;
      end else begin
        state_nxt_s    = ST_EMPTY;
        ir_valid_nxt_s = 1'b0;
      end
    end else if (issue_s) begin
      // A non-retiring issue is always a non-final uop
      state_nxt_s = ST_SEQ;
      if (uop_cnt_r < MAX_CNT) begin
        uop_cnt_nxt_s = uop_cnt_r + 5'd1;
      end else begin
        uop_cnt_nxt_s = uop_cnt_r;
      end
      if ((uop_cnt_r + 5'd1) == MAX_CNT) begin
        err_nxt_s = 1'b1;
      end else begin
        err_nxt_s = err_r;
      end
    end else if (fd_valid & accept_s) begin
      state_nxt_s    = ST_HELD;
      ir_nxt_s       = fd_instr;
      ir_valid_nxt_s = 1'b1;
      uop_cnt_nxt_s  = 5'd0;
    end else begin
      state_nxt_s = state_r;
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= ST_EMPTY;
      ir_r       <= 32'd0;
      ir_valid_r <= 1'b0;
      uop_cnt_r  <= 5'd0;
      err_r      <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      ir_r       <= ir_nxt_s;
      ir_valid_r <= ir_valid_nxt_s;
      uop_cnt_r  <= uop_cnt_nxt_s;
      err_r      <= err_nxt_s;
    end
  end

endmodule

// File: tb/tb_hazard3_uop_issue_ctrl.sv
// Testbench for hazard3_uop_issue_ctrl. A decompressor stub and a reference
// model live here; each stimulus cycle pushes expected outputs into queues
// that a separate monitor pops and compares on the falling edge.
module tb_hazard3_uop_issue_ctrl;

  localparam int MAXU = 16;
  localparam int NEVER_FINAL = 255;

  logic        clk = 1'b0;
  logic        rst_n, fd_valid, fd_ready;
  logic [31:0] fd_instr, dc_instr_in;
  logic        dc_is_uop, dc_is_final_uop, dc_uop_atomic;
  logic        dc_uop_stall, dc_uop_clear;
  logic        x_stall, x_flush, irq_req, irq_take;
  logic        d_valid, d_retire, err_overlong;
  logic [4:0]  uop_cnt;

  always #5 clk = ~clk;

  hazard3_uop_issue_ctrl #(.MAX_UOPS(MAXU)) dut (
    .clk(clk), .rst_n(rst_n),
    .fd_valid(fd_valid), .fd_instr(fd_instr), .fd_ready(fd_ready),
    .dc_instr_in(dc_instr_in),
    .dc_is_uop(dc_is_uop), .dc_is_final_uop(dc_is_final_uop),
    .dc_uop_atomic(dc_uop_atomic),
    .dc_uop_stall(dc_uop_stall), .dc_uop_clear(dc_uop_clear),
    .x_stall(x_stall), .x_flush(x_flush),
    .irq_req(irq_req), .irq_take(irq_take),
    .d_valid(d_valid), .d_retire(d_retire),
    .uop_cnt(uop_cnt), .err_overlong(err_overlong)
  );

  typedef struct packed {
    bit        rdy, dv, ret, take, clr, stall, err;
    bit [4:0]  cnt;
    bit [31:0] instr;
  } exp_t;

  typedef struct packed {
    bit [31:0] instr;
    bit        ret;
  } iss_t;

  exp_t cq[$];
  iss_t iq[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: held instruction, its uop length (0 = plain
  // instruction, NEVER_FINAL = stub that never ends), uops issued so far.
  bit        m_held = 1'b0;
  bit [31:0] m_ir = 32'd0;
  int        m_len = 0;
  int        m_n = 0;
  int        m_cnt = 0;
  bit        m_err = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input bit r, input bit fv, input logic [31:0] fi, input int fl,
                      input bit xs, input bit xf, input bit irq, input bit at);
    bit uop, fin, in_seq, irq_ok, iss, ret, take, clr, rdy;
    exp_t e;
    iss_t it;
    @(posedge clk);
    #1;
    uop    = m_held && (m_len != 0);
    fin    = uop && (m_len != NEVER_FINAL) && (m_n == m_len - 1);
    rst_n = r; fd_valid = fv; fd_instr = fi; x_stall = xs; x_flush = xf;
    irq_req = irq; dc_uop_atomic = at; dc_is_uop = uop; dc_is_final_uop = fin;
    in_seq = m_held && (m_n > 0);
    irq_ok = r && m_held && !xs && irq && !(in_seq && at);
    iss    = r && m_held && !xs && !xf && !irq_ok;
    ret    = iss && (!uop || fin);
    take   = irq_ok && !xf;
    clr    = xf || take || !r;
    rdy    = r && !xf && (!m_held || ret);
    e.rdy = rdy; e.dv = iss; e.ret = ret; e.take = take; e.clr = clr;
    e.stall = !iss && !clr; e.err = m_err; e.cnt = 5'(m_cnt); e.instr = m_ir;
    cq.push_back(e);
    if (iss) begin
      it.instr = m_ir; it.ret = ret;
      iq.push_back(it);
    end
    if (!r) begin
      m_held = 1'b0; m_ir = 32'd0; m_n = 0; m_cnt = 0; m_err = 1'b0;
    end else if (xf) begin
      m_held = 1'b0; m_n = 0; m_cnt = 0;
    end else if (take) begin
      m_n = 0; m_cnt = 0;
    end else if (ret || !m_held) begin
      if (fv && rdy) begin
        m_held = 1'b1; m_ir = fi; m_len = fl; m_n = 0; m_cnt = 0;
      end else if (ret) begin
        m_held = 1'b0;
      end
    end else if (iss) begin
      m_n++;
      if (m_cnt < MAXU) m_cnt++;
      if (m_cnt >= MAXU) m_err = 1'b1;
    end
  endtask

  task automatic idle();
    step(1'b1, 1'b0, 32'd0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic run(input int k, input bit irq, input bit at);
    for (int i = 0; i < k; i++) step(1'b1, 1'b0, 32'd0, 0, 1'b0, 1'b0, irq, at);
  endtask

  // Monitor: compare every cycle's outputs and every issued uop.
  exp_t mon_e;
  iss_t mon_i;
  always @(negedge clk) begin
    if (cq.size() > 0) begin
      mon_e = cq.pop_front();
      chk("fd_ready",     32'(fd_ready),     32'(mon_e.rdy));
      chk("d_valid",      32'(d_valid),      32'(mon_e.dv));
      chk("d_retire",     32'(d_retire),     32'(mon_e.ret));
      chk("irq_take",     32'(irq_take),     32'(mon_e.take));
      chk("dc_uop_clear", 32'(dc_uop_clear), 32'(mon_e.clr));
      chk("dc_uop_stall", 32'(dc_uop_stall), 32'(mon_e.stall));
      chk("uop_cnt",      32'(uop_cnt),      32'(mon_e.cnt));
      chk("err_overlong", 32'(err_overlong), 32'(mon_e.err));
      chk("dc_instr_in",  dc_instr_in,       mon_e.instr);
    end
    if (d_valid === 1'b1) begin
      if (iq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL issue_unexpected actual=1 expected=0 at %0t", $time);
      end else begin
        mon_i = iq.pop_front();
        chk("issue_instr",  dc_instr_in,   mon_i.instr);
        chk("issue_retire", 32'(d_retire), 32'(mon_i.ret));
      end
    end
  end

  initial begin
    rst_n = 1'b0; fd_valid = 1'b0; fd_instr = 32'd0; x_stall = 1'b0; x_flush = 1'b0;
    irq_req = 1'b0; dc_uop_atomic = 1'b0; dc_is_uop = 1'b0; dc_is_final_uop = 1'b0;

    // reset
    step(1'b0, 1'b0, 32'd0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 32'hdeadbeef, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle();

    // plain 32-bit instruction
    step(1'b1, 1'b1, 32'h00a00093, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(); idle();

    // back-to-back compressed instructions
    step(1'b1, 1'b1, 32'h00004505, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 32'h00004585, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(); idle();

    // cm.push, 5 uops, two stall cycles on the third uop
    step(1'b1, 1'b1, 32'h0000b8f2, 5, 1'b0, 1'b0, 1'b0, 1'b0);
    run(2, 1'b0, 1'b0);
    step(1'b1, 1'b0, 32'd0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 32'd0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    run(3, 1'b0, 1'b0);
    idle();

    // cm.popret interrupted at uop 2, then restarts from uop 0
    step(1'b1, 1'b1, 32'h0000be72, 6, 1'b0, 1'b0, 1'b0, 1'b0);
    run(2, 1'b0, 1'b0);
    step(1'b1, 1'b0, 32'd0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    run(6, 1'b0, 1'b0);
    idle();

    // irq held off by atomic uops until retire, taken on the next instruction
    step(1'b1, 1'b1, 32'h0000b872, 4, 1'b0, 1'b0, 1'b0, 1'b0);
    run(1, 1'b0, 1'b0);
    run(2, 1'b1, 1'b1);
    step(1'b1, 1'b1, 32'h00004505, 0, 1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b0, 32'd0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(); idle();

    // flush with irq pending at uop 1
    step(1'b1, 1'b1, 32'h0000ba72, 3, 1'b0, 1'b0, 1'b0, 1'b0);
    run(1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 32'h12345678, 0, 1'b0, 1'b1, 1'b1, 1'b0);
    idle();

    // stub that never signals final: saturate and set the sticky error
    step(1'b1, 1'b1, 32'h0000bafe, NEVER_FINAL, 1'b0, 1'b0, 1'b0, 1'b0);
    run(MAXU + 3, 1'b0, 1'b0);
    step(1'b1, 1'b0, 32'd0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(); idle();

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      int fl;
      fl = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 7));
      if ($urandom_range(0, 49) == 0) fl = NEVER_FINAL;
      step(($urandom_range(0, 199) != 0),
           ($urandom_range(0, 3) != 0),
           $urandom, fl,
           ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 22) == 0),
           ($urandom_range(0, 8) == 0),
           ($urandom_range(0, 2) == 0));
    end

    // final reset clears the sticky error
    step(1'b0, 1'b0, 32'd0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle();
    @(negedge clk);
    #1;
    chk("cq_drained", 32'(cq.size()), 32'd0);
    chk("iq_drained", 32'(iq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard3_uop_issue_ctrl.md
# hazard3_uop_issue_ctrl

Issue controller between the fetch/instruction buffer and the instruction decompressor. It holds the current instruction, presents it to the decompressor for as many cycles as its micro-op (uop) sequence requires, and drives the decompressor's uop stall/clear inputs. It also decides when an interrupt may cut into a Zcmp uop sequence and discards state on pipeline flush. The decompressor's uop step counter is sequenced entirely from here.

## Interface
- `MAX_UOPS`, default 16: uop-count limit for a single held instruction; reaching it without a final uop sets the error flag.
- `clk` input 1: clock.
- `rst_n` input 1: synchronous active-low reset.
- `fd_valid` input 1: fetch offers an instruction.
- `fd_instr` input 32: offered instruction, 16-bit in [15:0] or 32-bit.
- `fd_ready` output 1: the instruction is accepted this cycle.
- `dc_instr_in` output 32: held instruction, sent to the decompressor.
- `dc_is_uop` input 1: the decompressor output is a uop.
- `dc_is_final_uop` input 1: the current uop is the last in its sequence.
- `dc_uop_atomic` input 1: the current uop must not be interrupted.
- `dc_uop_stall` output 1: hold the decompressor uop counter.
- `dc_uop_clear` output 1: reset the decompressor uop counter to 0.
- `x_stall` input 1: downstream cannot accept an issue this cycle.
- `x_flush` input 1: pipeline redirect; discard the held instruction.
- `irq_req` input 1: interrupt pending (level).
- `irq_take` output 1: interrupt taken this cycle (pulse).
- `d_valid` output 1: a uop or instruction is issued downstream this cycle.
- `d_retire` output 1: the held instruction completes this cycle.
- `uop_cnt` output 5: number of uops issued for the held instruction.
- `err_overlong` output 1: sticky flag, set when a sequence reaches `MAX_UOPS` uops.

## Operation
- Registered state:
  - `ir` (32 bits), reset 0.
  - `ir_valid`, reset 0.
  - `uop_cnt`, reset 0.
  - `err_overlong`, reset 0.
  - `state`, one of EMPTY, HELD or SEQ; reset EMPTY.
- `dc_instr_in = ir` at all times.
- Combinational terms:
  - `can_irq = ir_valid & ~x_stall & irq_req & ~(state==SEQ & dc_uop_atomic)`.
  - `issue = ir_valid & ~x_stall & ~x_flush & ~can_irq`.
  - `d_valid = issue`.
  - `d_retire = issue & (~dc_is_uop | dc_is_final_uop)`.
  - `irq_take = can_irq & ~x_flush`.
  - `dc_uop_clear = x_flush | irq_take | ~rst_n`.
  - `dc_uop_stall = ~issue & ~dc_uop_clear`.
  - `fd_ready = rst_n & ~x_flush & (~ir_valid | d_retire)`.
- Priority order is reset, then flush, then irq, then issue.
- State transitions:
  - EMPTY → HELD on `fd_valid & fd_ready`. `ir` loads `fd_instr` and `uop_cnt` clears to 0.
  - HELD → SEQ when `issue & dc_is_uop & ~dc_is_final_uop`.
  - HELD/SEQ → HELD on `d_retire` with `fd_valid`: back-to-back load, no bubble.
  - HELD/SEQ → EMPTY on `d_retire` without `fd_valid`.
  - Any state → EMPTY on `x_flush`. `ir_valid` clears, `uop_cnt` clears to 0, and the fetch word is not accepted.
  - On `irq_take`, SEQ/HELD → HELD. `ir` is retained so the instruction restarts from uop 0 after the handler, and `uop_cnt` clears to 0.
- Counters:
  - `uop_cnt` increments on each `issue` that does not retire.
  - `uop_cnt` saturates at `MAX_UOPS`.
  - When `uop_cnt` reaches `MAX_UOPS` in SEQ, `err_overlong` is set. It is cleared only by reset.
- Interrupts are never taken while `dc_uop_atomic` is set in SEQ. The pending `irq_req` waits until the sequence retires and is then taken at the next instruction boundary.
- `x_stall` in SEQ holds the counter via `dc_uop_stall`; the same uop is re-presented the next cycle.

## Timing
- Issue latency is 1 cycle: the instruction is accepted at edge N and `d_valid` can assert in cycle N+1.
- A sequence of k uops with no stalls has `d_valid` high for k consecutive cycles; `d_retire` asserts on the k-th.
- Sustained throughput is 1 non-uop instruction per cycle.
- All outputs other than `dc_instr_in`, `uop_cnt` and `err_overlong` are combinational from registered state and inputs.
- During reset (`rst_n` low at the edge):
  - `d_valid`, `d_retire`, `irq_take` and `fd_ready` are 0.
  - `dc_uop_clear` is 1.
- Reset mid-sequence leaves EMPTY with `uop_cnt` at 0 after the edge.
- `x_flush` and `irq_req` in the same cycle: the flush wins and `irq_take` is 0.

## Test plan
- 32-bit `0x00a00093` offered, no stall → `fd_ready` is 1. Next cycle `d_valid` = `d_retire` = 1 and `uop_cnt` = 0.
- Back-to-back compressed `0x4505`, `0x4585` → one issue per cycle, `fd_ready` stays 1, no bubble.
- cm.push with 5 uops (final on 5th), `x_stall` on uop 3 for 2 cycles → `d_valid` 0 for 2 cycles and `dc_uop_stall` 1. Retire on 7th cycle with `uop_cnt` = 4 before retire.
- cm.popret with `irq_req` raised at uop 2 (non-atomic) → `irq_take` = 1, `dc_uop_clear` = 1, `ir` unchanged and `uop_cnt` = 0.
- `irq_req` raised during an atomic uop (`dc_uop_atomic` = 1) → no take until `d_retire`. `irq_take` = 1 on the next held instruction.
- `x_flush` at uop 1 with `irq_req` = 1 → `irq_take` = 0, EMPTY next cycle, `fd_ready` 0 that cycle. Separately, a stub that never asserts final → `err_overlong` = 1 after 16 uops, stays set until reset.
